// File: rtl/expr_buffer.sv
// ---------------------------------------------------------------------------
// expr_buffer
//   Token line buffer placed after the keypad encoder. Holds the expression
//   being typed as token codes, keeps an edit cursor, executes the encoder's
//   one-cycle command pulses (insert / backspace / cursor left / cursor right)
//   and, on evaluate, streams the stored tokens over a valid/ready interface.
//
// Ports
//   clock, reset        : single clock, asynchronous active-high reset
//   dataIn              : token code, sampled with insert
//   insert              : insert dataIn at the cursor
//   del_pulse           : delete the token left of the cursor
//   ptrLeft_pulse       : cursor - 1
//   ptrRight_pulse      : cursor + 1
//   eval_pulse          : stream the buffer out
//   size, ptr           : stored token count and cursor position (0..size)
//   full                : size == depth
//   busy                : an insert/delete shift or a stream is in progress
//   dropped             : registered one-cycle pulse for a discarded command
//   tok_data/valid/last : token stream towards the evaluator
//   tok_ready           : evaluator accepts the current token
// ---------------------------------------------------------------------------
module expr_buffer #(
    parameter int width = 8,
    parameter int depth = 32,
    localparam int AW   = $clog2(depth + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [width-1:0] dataIn,
    input  logic             insert,
    input  logic             del_pulse,
    input  logic             ptrLeft_pulse,
    input  logic             ptrRight_pulse,
    input  logic             eval_pulse,
    output logic [AW-1:0]    size,
    output logic [AW-1:0]    ptr,
    output logic             full,
    output logic             busy,
    output logic             dropped,
    output logic [width-1:0] tok_data,
    output logic             tok_valid,
    output logic             tok_last,
    input  logic             tok_ready
);

    // Index width for the storage array (addresses 0..depth-1).
    localparam int IW = (depth > 1) ? $clog2(depth) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_R = 2'd1,
        SHIFT_L = 2'd2,
        STREAM  = 2'd3
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     j_q;
    logic [AW-1:0]     size_q;
    logic [AW-1:0]     ptr_q;
    logic              dropped_q;
    logic [width-1:0]  hold_q;
    logic [width-1:0]  mem_q [depth];

    logic              full_w;
    logic              any_cmd;
    logic [AW-1:0]     size_m1;
    logic [IW-1:0]     j_idx;
    logic [IW-1:0]     j_dec_idx;
    logic [IW-1:0]     j_inc_idx;
    logic              mem_we;
    logic [width-1:0]  mem_wd;

    assign full_w    = (size_q == AW'(depth));
    assign any_cmd   = insert | del_pulse | ptrLeft_pulse | ptrRight_pulse | eval_pulse;
    assign size_m1   = size_q - AW'(1);
    assign j_idx     = j_q[IW-1:0];
    assign j_dec_idx = j_idx - IW'(1);
    assign j_inc_idx = j_idx + IW'(1);

    // Storage write port. Both shift directions move one token per cycle
    // at index j; the final SHIFT_R cycle (j == ptr) drops the held token
    // into the gap that opened under the cursor.
    always_comb begin
        mem_we = 1'b0;
        mem_wd = hold_q;
        case (state_q)
            SHIFT_R: begin
                mem_we = 1'b1;
                if (j_q != ptr_q) begin
                    mem_wd = mem_q[j_dec_idx];
                end
            end
            SHIFT_L: begin
                if (j_q != size_m1) begin
                    mem_we = 1'b1;
                    mem_wd = mem_q[j_inc_idx];
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Token storage and the insert hold register carry no reset; contents
    // beyond size are meaningless, so a reset only needs to clear size.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[j_idx] <= mem_wd;
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == IDLE && insert && !full_w) begin
            hold_q <= dataIn;
        end
    end

    // Control FSM. Commands are honoured only in IDLE, highest priority
    // first; any pulse that is not executed raises dropped next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            j_q       <= '0;
            size_q    <= '0;
            ptr_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (insert) begin
                        dropped_q <= full_w | del_pulse | ptrLeft_pulse |
                                     ptrRight_pulse | eval_pulse;
                        if (!full_w) begin
                            j_q     <= size_q;
                            state_q <= SHIFT_R;
                        end
                    end else if (del_pulse) begin
                        dropped_q <= ptrLeft_pulse | ptrRight_pulse | eval_pulse;
                        // Backspace at the start of the line is a silent no-op.
                        if (ptr_q != '0) begin
                            j_q     <= ptr_q - AW'(1);
                            state_q <= SHIFT_L;
                        end
                    end else if (ptrLeft_pulse) begin
                        dropped_q <= ptrRight_pulse | eval_pulse;
                        if (ptr_q != '0) begin
                            ptr_q <= ptr_q - AW'(1);
                        end
                    end else if (ptrRight_pulse) begin
                        dropped_q <= eval_pulse;
                        if (ptr_q != size_q) begin
                            ptr_q <= ptr_q + AW'(1);
                        end
                    end else if (eval_pulse) begin
                        if (size_q != '0) begin
                            j_q     <= '0;
                            state_q <= STREAM;
                        end
                    end
                end
                SHIFT_R: begin
                    dropped_q <= any_cmd;
                    if (j_q == ptr_q) begin
                        size_q  <= size_q + AW'(1);
                        ptr_q   <= ptr_q + AW'(1);
                        state_q <= IDLE;
                    end else begin
                        j_q <= j_q - AW'(1);
                    end
                end
                SHIFT_L: begin
                    dropped_q <= any_cmd;
                    if (j_q == size_m1) begin
                        size_q  <= size_m1;
                        ptr_q   <= ptr_q - AW'(1);
                        state_q <= IDLE;
                    end else begin
                        j_q <= j_q + AW'(1);
                    end
                end
                STREAM: begin
                    dropped_q <= any_cmd;
                    if (tok_ready) begin
                        if (j_q == size_m1) begin
                            state_q <= IDLE;
                        end else begin
                            j_q <= j_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign size      = size_q;
    assign ptr       = ptr_q;
    assign full      = full_w;
    assign busy      = (state_q != IDLE);
    assign dropped   = dropped_q;
    assign tok_valid = (state_q == STREAM);
    assign tok_data  = mem_q[j_idx];
    assign tok_last  = (j_q == size_m1);

endmodule

// File: tb/tb_expr_buffer.sv
module tb_expr_buffer;

    localparam int W  = 8;
    localparam int D  = 32;
    localparam int AW = $clog2(D + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  dataIn;
    logic          insert, del_pulse, ptrLeft_pulse, ptrRight_pulse, eval_pulse;
    logic [AW-1:0] size, ptr;
    logic          full, busy, dropped;
    logic [W-1:0]  tok_data;
    logic          tok_valid, tok_last, tok_ready;

    expr_buffer #(.width(W), .depth(D)) dut (
        .clock          (clock),
        .reset          (reset),
        .dataIn         (dataIn),
        .insert         (insert),
        .del_pulse      (del_pulse),
        .ptrLeft_pulse  (ptrLeft_pulse),
        .ptrRight_pulse (ptrRight_pulse),
        .eval_pulse     (eval_pulse),
        .size           (size),
        .ptr            (ptr),
        .full           (full),
        .busy           (busy),
        .dropped        (dropped),
        .tok_data       (tok_data),
        .tok_valid      (tok_valid),
        .tok_last       (tok_last),
        .tok_ready      (tok_ready)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the expression as a plain list plus a cursor index.
    int q[$];
    int mptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rtok();
        int r;
        r = $urandom_range(15);
        return (r < 10) ? W'(r) : W'(8'hA0 + (r - 10));
    endfunction

    // Drive one clock's worth of command pulses; returns #1 after the edge.
    task automatic pulse(input bit i, input bit d, input bit l, input bit r,
                         input bit e, input logic [W-1:0] tok);
        insert = i; del_pulse = d; ptrLeft_pulse = l; ptrRight_pulse = r;
        eval_pulse = e; dataIn = tok;
        @(posedge clock); #1;
        insert = 0; del_pulse = 0; ptrLeft_pulse = 0; ptrRight_pulse = 0;
        eval_pulse = 0; dataIn = W'($urandom);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_size"}, 32'(size), q.size());
        chk({tag, "_ptr"},  32'(ptr),  mptr);
        chk({tag, "_full"}, 32'(full), (q.size() == D) ? 1 : 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_size"},  32'(size), 0);
        chk({tag, "_ptr"},   32'(ptr), 0);
        chk({tag, "_full"},  32'(full), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_drop"},  32'(dropped), 0);
        chk({tag, "_valid"}, 32'(tok_valid), 0);
        chk({tag, "_last"},  32'(tok_last), 0);
    endtask

    task automatic op_insert(input logic [W-1:0] tok);
        int n, exp_busy;
        bit exp_drop;
        exp_drop = (q.size() == D);
        exp_busy = exp_drop ? 0 : q.size() - mptr + 1;
        pulse(1, 0, 0, 0, 0, tok);
        chk("ins_dropped", 32'(dropped), exp_drop);
        wait_idle(n);
        chk("ins_busy_cycles", n, exp_busy);
        if (!exp_drop) begin
            q.insert(mptr, int'(tok));
            mptr++;
        end
        check_state("ins");
    endtask

    task automatic op_del();
        int n, exp_busy;
        exp_busy = (mptr > 0) ? q.size() - mptr + 1 : 0;
        pulse(0, 1, 0, 0, 0, 0);
        chk("del_dropped", 32'(dropped), 0);
        wait_idle(n);
        chk("del_busy_cycles", n, exp_busy);
        if (mptr > 0) begin
            q.delete(mptr - 1);
            mptr--;
        end
        check_state("del");
    endtask

    task automatic op_move(input bit left);
        pulse(0, 0, left, !left, 0, 0);
        chk("move_dropped", 32'(dropped), 0);
        chk("move_busy", 32'(busy), 0);
        if (left && mptr > 0) mptr--;
        if (!left && mptr < q.size()) mptr++;
        check_state("move");
    endtask

    // Evaluate and collect the stream. ready_pct sets how often tok_ready is
    // offered; poke drives an insert pulse while the stream is stalled.
    task automatic op_stream(input int ready_pct, input bit poke);
        int idx, cyc;
        bit done;
        idx = 0; cyc = 0; done = 0;
        pulse(0, 0, 0, 0, 1, 0);
        if (q.size() == 0) begin
            chk("strm_empty_valid", 32'(tok_valid), 0);
            chk("strm_empty_busy", 32'(busy), 0);
            return;
        end
        chk("strm_first_valid", 32'(tok_valid), 1);
        while (!done && cyc < 400) begin
            if (poke && cyc < 2) tok_ready = 1'b0;
            else tok_ready = ($urandom_range(99) < ready_pct);
            insert = (poke && cyc == 1);
            dataIn = W'(8'h07);
            if (poke && cyc == 2) chk("strm_poke_dropped", 32'(dropped), 1);
            chk("strm_valid", 32'(tok_valid), 1);
            chk("strm_data", 32'(tok_data), q[idx]);
            chk("strm_last", 32'(tok_last), (idx == q.size() - 1) ? 1 : 0);
            if (tok_ready) begin
                if (idx == q.size() - 1) done = 1;
                idx++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        insert = 0; tok_ready = 0;
        chk("strm_count", idx, q.size());
        if (ready_pct == 100 && !poke) chk("strm_cycles", cyc, q.size());
        chk("strm_end_valid", 32'(tok_valid), 0);
        check_state("strm");
    endtask

    task automatic reset_now(input string tag);
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        #1;
        reset = 1'b0;
        q.delete();
        mptr = 0;
        @(posedge clock); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1; dataIn = 0; tok_ready = 0;
        insert = 0; del_pulse = 0; ptrLeft_pulse = 0; ptrRight_pulse = 0; eval_pulse = 0;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst_held");
        reset = 0;
        @(posedge clock); #1;

        // "12+3" typed with idle gaps, then streamed at full rate.
        op_insert(8'h01); repeat (2) @(posedge clock); #1;
        op_insert(8'h02); repeat (2) @(posedge clock); #1;
        op_insert(8'hA0); repeat (2) @(posedge clock); #1;
        op_insert(8'h03);
        chk("seq_size4", 32'(size), 4);
        op_stream(100, 0);

        // Cursor to 2, insert mid-line, then delete it again.
        op_move(1); op_move(1);
        chk("seq_ptr2", 32'(ptr), 2);
        op_insert(8'hA2);
        op_stream(100, 0);
        chk("seq_ptr3", 32'(ptr), 3);
        op_del();
        op_stream(100, 0);
        while (mptr > 0) op_move(1);
        op_del();

        // Coinciding pulses: insert wins, the lower one is discarded.
        pulse(1, 0, 0, 1, 0, 8'h09);
        chk("coinc_dropped", 32'(dropped), 1);
        wait_idle(n);
        chk("coinc_busy", n, q.size() + 1);
        q.insert(mptr, 9); mptr++;
        check_state("coinc");
        op_stream(100, 0);

        // Random editing session against the model.
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(9))
                0, 1, 2, 3: op_insert(rtok());
                4, 5:       op_del();
                6:          op_move(1);
                7:          op_move(0);
                default:    op_stream(50, 0);
            endcase
        end
        op_stream(100, 0);

        // Fill to capacity and push past it.
        while (q.size() < D) op_insert(rtok());
        chk("full_flag", 32'(full), 1);
        op_insert(8'h04);
        chk("full_size", 32'(size), D);
        while (mptr < q.size()) op_move(0);
        op_move(0);
        chk("right_at_end", 32'(ptr), D);
        op_stream(50, 1);
        op_stream(50, 0);

        // Reset in the middle of a shift.
        repeat (3) op_del();
        while (mptr > 0) op_move(1);
        pulse(1, 0, 0, 0, 0, 8'h06);
        chk("midshift_busy", 32'(busy), 1);
        @(posedge clock); #1;
        reset_now("rst_midshift");

        // Reset in the middle of a stream.
        op_insert(8'h01); op_insert(8'h02); op_insert(8'h03);
        tok_ready = 0;
        pulse(0, 0, 0, 0, 1, 0);
        chk("midstream_valid", 32'(tok_valid), 1);
        tok_ready = 1;
        @(posedge clock); #1;
        tok_ready = 0;
        reset_now("rst_midstream");

        op_insert(8'h05);
        chk("single_size", 32'(size), 1);
        op_stream(100, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/expr_buffer.md
# expr_buffer

Token line buffer that sits directly downstream of the keypad encoder. Stores the expression being typed as a sequence of token codes (digits 0–9, operators 0xA0–0xA5) and maintains an edit cursor. Executes the encoder's one-cycle command pulses: insert at cursor, backspace, cursor left/right. On evaluate, it streams the stored tokens in order over a valid/ready interface to the evaluator.

## Interface
- `width`, 8, token width in bits.
- `depth`, 32, token capacity; must be ≥ 2. `AW` = $clog2(depth+1) (localparam).
- `clock`  in  1  single clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `dataIn`  in  width  token code; sampled only in the cycle `insert` is high.
- `insert`  in  1  one-cycle pulse: insert `dataIn` at the cursor.
- `del_pulse`  in  1  one-cycle pulse: delete the token left of the cursor.
- `ptrLeft_pulse`  in  1  one-cycle pulse: cursor −1.
- `ptrRight_pulse`  in  1  one-cycle pulse: cursor +1.
- `eval_pulse`  in  1  one-cycle pulse: stream the buffer out.
- `size`  out  AW  number of stored tokens.
- `ptr`  out  AW  cursor position, 0..size. Tokens [0,ptr) are left of the cursor.
- `full`  out  1  size == depth.
- `busy`  out  1  state ≠ IDLE.
- `dropped`  out  1  one-cycle pulse when an accepted-class command is discarded.
- `tok_data`  out  width  streamed token.
- `tok_valid`  out  1  `tok_data` valid.
- `tok_last`  out  1  marks the final token of the stream.
- `tok_ready`  in  1  downstream accepts the token.

## Operation
- Storage: `mem[0..depth-1]` is register array, not reset. Contents at indices ≥ size are don't-care.
- FSM states: IDLE, SHIFT_R, SHIFT_L, STREAM. Index register `j`, hold register `hold`.
- Commands are sampled only in IDLE. Priority when pulses coincide: insert > del > ptrLeft > ptrRight > eval. Exactly one command executes; lower-priority pulses in that cycle are discarded and `dropped` is pulsed.
- Any command pulse outside IDLE is discarded and pulses `dropped`.
- Insert, when size < depth: `hold`<=dataIn, `j`<=size, go to SHIFT_R.
  - Insert when full: no change; pulse `dropped`.
- SHIFT_R, each cycle:
  - if j == ptr: mem[ptr]<=hold, size+1, ptr+1, go to IDLE.
  - else: mem[j]<=mem[j−1], j−1.
- Del, when ptr > 0: `j`<=ptr−1, go to SHIFT_L.
  - Del when ptr == 0: no change; no `dropped`.
- SHIFT_L, each cycle:
  - if j == size−1: size−1, ptr−1, go to IDLE.
  - else: mem[j]<=mem[j+1], j+1.
- ptrLeft: ptr−1 if ptr > 0, else no-op. ptrRight: ptr+1 if ptr < size, else no-op. Both complete in a single cycle and stay in IDLE.
- Eval with size > 0: j<=0, go to STREAM. Eval with size == 0: no-op.
- STREAM:
  - tok_valid = 1; tok_data = mem[j]; tok_last = (j == size−1).
  - On tok_valid & tok_ready: if last, go to IDLE; else j+1.
  - Buffer contents, size and ptr are unchanged by streaming.
- Outputs `tok_*` are combinational from state/j/mem; `tok_valid` = (state == STREAM). `tok_data` and `tok_last` are don't-care when `tok_valid` is low.

## Timing
- Reset values: size=0, ptr=0, full=0, busy=0, dropped=0, tok_valid=0, tok_last=0, state=IDLE, j=0. Reset is asynchronous and takes effect mid-shift or mid-stream, abandoning the operation. Buffer then reads as empty.
- Insert latency: accepted at edge N. `busy` is high for (size−ptr)+1 cycles. size/ptr update on the edge that leaves SHIFT_R. Insert at the end (ptr==size) is busy for exactly 1 cycle.
- Del latency: busy for (size−ptr)+1 cycles. Delete of the last token is busy for 1 cycle.
- ptrLeft/ptrRight: `ptr` updates on the accepting edge; busy stays low.
- Stream: first `tok_valid` appears the cycle after the accepting edge. One token per cycle while `tok_ready` is held high. Data is held stable while `tok_valid` & !`tok_ready`.
- `dropped` is registered: high the cycle after the offending edge, for 1 cycle.
- `full` is combinational from `size`.

## Test plan
- Reset, then insert 1, 2, 0xA0, 3 with idle gaps → size=4, ptr=4. Eval with tok_ready=1 → tokens 01,02,A0,03 on consecutive cycles, tok_last on 03, then busy=0.
- From "12+3", ptrLeft ×2 (ptr=2), insert 0xA2 → busy for 3 cycles. Stream gives 01,02,A2,A0,03; size=5, ptr=3.
- From "12A2A03" with ptr=3, del → busy 3 cycles; stream gives 01,02,A0,03; ptr=2. Del at ptr=0 → no change, dropped=0.
- Fill to depth=32, insert again → dropped pulses once, size stays 32, full=1. ptrRight at ptr==size → ptr unchanged.
- Stream with tok_ready toggling 1,0,0,1… → each token held stable until accepted, no loss or duplication. Insert pulse during STREAM → dropped, buffer unchanged.
- Assert reset mid-SHIFT_R and mid-STREAM → all outputs at reset values asynchronously. Subsequent insert of 5 → size=1, stream yields single token 05 with tok_last=1.
